// File: rtl/alu_op_sequencer.sv
// Requester-side sequencer for the packed 8-bit ALU operand bus: packs one request,
// waits a fixed settle time, samples the result and returns it with optional checking.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_sel,
    input  logic [2:0]       req_a,
    input  logic [1:0]       req_b,
    input  logic             req_chk,
    input  logic [7:0]       req_exp,
    output logic [7:0]       bus_out,
    input  logic [7:0]       bus_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_mismatch,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  settle_cnt_r;
    logic        chk_r;
    logic [7:0]  exp_r;
    logic        accept_s;
    logic        sample_s;
    logic        rsp_done_s;
    logic        req_ready_r;
    logic        busy_r;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        sample_s    = 1'b0;
        rsp_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = SETTLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == 4'd0) begin
                    sample_s    = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Operand bus, request latch, settle timer and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_out      <= 8'd0;
            chk_r        <= 1'b0;
            exp_r        <= 8'd0;
            settle_cnt_r <= 4'd0;
            rsp_valid    <= 1'b0;
            rsp_result   <= 8'd0;
            rsp_mismatch <= 1'b0;
        end else begin
            if (accept_s) begin
                bus_out      <= {req_sel, req_a, req_b};
                chk_r        <= req_chk;
                exp_r        <= req_exp;
                settle_cnt_r <= SETTLE_LOAD;
            end else if (state_r == SETTLE && settle_cnt_r != 4'd0) begin
                settle_cnt_r <= settle_cnt_r - 4'd1;
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
            // Only the value present at the sample edge matters; earlier glitches are ignored.
            if (sample_s) begin
                rsp_valid    <= 1'b1;
                rsp_result   <= bus_in;
                rsp_mismatch <= chk_r && (bus_in != exp_r);
            end else if (rsp_done_s) begin
                rsp_valid    <= 1'b0;
            end else begin
                rsp_valid    <= rsp_valid;
            end
        end
    end

    // Completed and mismatching response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= {CNT_W{1'b0}};
            err_count <= {CNT_W{1'b0}};
        end else if (rsp_done_s) begin
            txn_count <= sat_inc(txn_count);
            if (rsp_mismatch) begin
                err_count <= sat_inc(err_count);
            end else begin
                err_count <= err_count;
            end
        end else begin
            txn_count <= txn_count;
            err_count <= err_count;
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;

endmodule
